// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter (and its receive counterpart).
// Contents: frame geometry, serializer state encoding, and the baud-divider
// derivation, so both directions agree on the bit period.
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 10;  // start + 8 data + stop

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // Clock cycles per bit; floor division, callers must keep the result >= 2.
    function automatic int unsigned n_clocks(input int unsigned clock_frequency,
                                             input int unsigned baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO for the UART transmitter.
// Ports:
//   clock    in  1      clock
//   reset    in  1      synchronous active-high reset (flushes the queue)
//   push     in  1      write wr_data (ignored while full)
//   pop      in  1      advance read pointer (ignored while empty)
//   wr_data  in  WIDTH  data to enqueue
//   rd_data  out WIDTH  head of queue (valid while ~empty)
//   full     out 1      count == DEPTH
//   empty    out 1      count == 0
module uart_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_BITS,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) wide, so they wrap without explicit compare.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_transmit.sv
// Buffered UART transmitter: bytes accepted on a ready/valid interface are
// queued in uart_fifo and serialized as 8N1 frames, LSB first.
// Ports:
//   i_clock       in  1  clock
//   i_reset       in  1  synchronous active-high reset; aborts any frame in progress
//   i_data        in  8  byte to transmit
//   i_data_valid  in  1  i_data valid
//   o_data_ready  out 1  queue can accept a byte (low while in reset)
//   o_tx          out 1  registered serial line, idle high
//   o_busy        out 1  frame in progress or queue non-empty
module uart_transmit
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
    parameter int unsigned BAUD_RATE       = 115_200,
    parameter int unsigned FIFO_DEPTH      = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [DATA_BITS-1:0] i_data,
    input  logic                 i_data_valid,
    output logic                 o_data_ready,
    output logic                 o_tx,
    output logic                 o_busy
);

    localparam int unsigned      N_CLOCKS = n_clocks(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int unsigned      CNT_W    = $clog2(N_CLOCKS);
    localparam int unsigned      IDX_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_CLOCKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_state_t          state, state_next;
    logic [CNT_W-1:0]     cnt, cnt_next;
    logic [IDX_W-1:0]     bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0] shift, shift_next;
    logic                 tx, tx_next;

    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic [DATA_BITS-1:0] head;
    logic                 bit_done;

    assign o_data_ready = !full && !i_reset;
    assign push         = i_data_valid && o_data_ready;
    assign o_tx         = tx;
    assign o_busy       = (state != IDLE) || !empty;
    assign bit_done     = (cnt == CNT_LAST);

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (i_clock),
        .reset   (i_reset),
        .push    (push),
        .pop     (pop),
        .wr_data (i_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bit_idx <= bit_idx_next;
            shift   <= shift_next;
            tx      <= tx_next;
        end
    end

    // tx is computed one cycle ahead so the line value is registered. The shift
    // register is pre-shifted as each bit is launched, so shift[0] is always the
    // next data bit to put on the line.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        tx_next      = tx;
        pop          = 1'b0;

        case (state)
            IDLE: begin
                tx_next  = 1'b1;
                cnt_next = '0;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_next = head;
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end

            START: begin
                if (bit_done) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    tx_next      = shift[0];
                    shift_next   = shift >> 1;
                    state_next   = DATA;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            DATA: begin
                if (bit_done) begin
                    cnt_next = '0;
                    if (bit_idx == IDX_LAST) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                        tx_next      = shift[0];
                        shift_next   = shift >> 1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            STOP: begin
                if (bit_done) begin
                    cnt_next = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_next = head;
                        tx_next    = 1'b0;
                        state_next = START;
                    end else begin
                        tx_next    = 1'b1;
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            default: begin
                tx_next    = 1'b1;
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_transmit.sv
// Self-checking bench for uart_transmit (N_CLOCKS = 8, FIFO depth 4).
// Accepted bytes go into a scoreboard queue tagged with their acceptance edge;
// a negedge monitor decodes the line against the 8N1 frame of the queue head
// and checks start timing, o_busy and o_data_ready against a queue model.
module tb_uart_transmit;

    localparam int unsigned N_BIT = 8;
    localparam int unsigned DEPTH = 4;
    localparam int          FRAME_CYCLES = 10 * N_BIT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       ready;
    logic       tx;
    logic       busy;

    uart_transmit #(
        .CLOCK_FREQUENCY (8),
        .BAUD_RATE       (1),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_data       (data),
        .i_data_valid (valid),
        .o_data_ready (ready),
        .o_tx         (tx),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] byte_val;
        int         accept_edge;
    } item_t;

    item_t      q[$];
    item_t      cur;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         in_frame = 1'b0;
    int         idx = 0;
    logic [9:0] frame_bits;
    int         prev_end = -100;
    bit         rst_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    // Monitor / scoreboard. At a negedge, cyc == number of posedges seen so far.
    always @(negedge clk) begin
        bit sampled;
        int exp_start;
        sampled = 1'b0;
        if (rst) begin
            check("ready_in_reset", {31'b0, ready}, 32'd0);
            q.delete();
            in_frame = 1'b0;
            prev_end = -100;
        end else begin
            if (rst_prev) begin
                check("tx_after_reset", {31'b0, tx}, 32'd1);
                check("busy_after_reset", {31'b0, busy}, 32'd0);
            end
            if (!in_frame && tx === 1'b0 && q.size() > 0) begin
                cur = q.pop_front();
                exp_start = (cur.accept_edge + 1 > prev_end + 1) ? cur.accept_edge + 1 : prev_end + 1;
                check("start_edge", cyc, exp_start);
                frame_bits = {1'b1, cur.byte_val, 1'b0};
                idx = 0;
                in_frame = 1'b1;
            end
            if (in_frame) begin
                sampled = 1'b1;
                check("frame_bit", {31'b0, tx}, {31'b0, frame_bits[idx / N_BIT]});
                idx++;
                if (idx == FRAME_CYCLES) begin
                    in_frame = 1'b0;
                    prev_end = cyc;
                end
            end else begin
                check("idle_line", {31'b0, tx}, 32'd1);
            end
            check("busy", {31'b0, busy}, {31'b0, (sampled || q.size() > 0)});
            check("ready", {31'b0, ready}, {31'b0, (q.size() < DEPTH)});
            if (valid && ready) q.push_back('{byte_val: data, accept_edge: cyc + 1});
        end
        rst_prev = rst;
    end

    // Presents b and leaves valid high on return (aligned to posedge + 1).
    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        data  = b;
        valid = 1'b1;
        @(negedge clk);
        while (!ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout byte %0h: ready stayed %0b expected 1", b, ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        valid = 1'b0;
        while ((q.size() != 0 || in_frame) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_done", {31'b0, (q.size() != 0 || in_frame)}, 32'd0);
        idle(2);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // Single 0x55: start edge = accept + 1, 80 frame cycles, then not busy.
        push_byte(8'h55);
        wait_idle(300);

        // Burst of 10 with valid held: FIFO fills, frames back to back.
        for (int i = 0; i < 10; i++) push_byte(8'h10 + 8'(i));
        wait_idle(2000);

        // Edge values.
        push_byte(8'hA5);
        push_byte(8'h00);
        push_byte(8'hFF);
        wait_idle(600);

        // Fill FIFO, then hold 0xEE while not ready; must appear exactly once.
        for (int i = 0; i < 5; i++) push_byte(8'h20 + 8'(i));
        push_byte(8'hEE);
        wait_idle(1000);

        // Reset in the middle of 0x3C data bits with two bytes queued.
        push_byte(8'h3C);
        push_byte(8'h11);
        push_byte(8'h22);
        valid = 1'b0;
        n = 0;
        while (!(in_frame && idx >= 20) && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(100);
        push_byte(8'h81);
        wait_idle(300);

        // Randomized traffic with random gaps and occasional drains.
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            if (gap != 0) idle(gap);
            push_byte(8'($urandom_range(0, 255)));
            if ($urandom_range(0, 7) == 0) wait_idle(1000);
        end
        wait_idle(2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
